// File: rtl/ahb_master_arbiter.sv
// Purpose: two-master AHB-Lite arbiter/sequencer; fetch port is master 0, data port is master 1.
// Latency: request sampled in IDLE -> ready pulse 3 cycles later at zero wait; +1 cycle per HREADY-low cycle.
// Backpressure: HREADY low stalls ADDR/DATA with every output held; masters hold req until their ready pulse.
// Optional feature: define AHB_ARB_FAIR_EN to enable the fetch anti-starvation counter (STARVE_LIMIT).
module ahb_master_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   // fetch port (master 0)
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   // data port (master 1)
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_write,
   input  logic [2:0]  d_size,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   // AHB-Lite bus
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] SIZE_WORD     = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   // One master's request as seen by the bus, bundled so the winner is a single mux.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } req_t;

   state_t      state;
   logic        owner_d;      // 1 = data port owns the transfer in flight
   logic [31:0] hold_wdata;   // write data kept until the data phase
   logic        grant_any;
   logic        grant_d;
   req_t        win_req;

   assign grant_any = i_req | d_req;

`ifdef AHB_ARB_FAIR_EN
   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt;
   logic          force_fetch;

   // Fetch has lost STARVE_LIMIT contested rounds in a row: give it this one.
   assign force_fetch = (starve_cnt == CW'(STARVE_LIMIT)) && i_req && d_req;
   assign grant_d     = d_req && !force_fetch;

   // Count consecutive data wins taken while fetch was waiting; any other grant restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if ((state == IDLE) && grant_any) begin
         if (grant_d && i_req) begin
            starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end
      end
   end
`else
   // Without the fairness counter the limit has no effect.
   wire [31:0] unused_starve_limit = STARVE_LIMIT;

   assign grant_d = d_req;
`endif

   // Select the winning master's request; fetch is always a word read.
   always_comb begin
      win_req = '0;
      if (grant_d) begin
         win_req.addr  = d_addr;
         win_req.write = d_write;
         win_req.size  = d_size;
         win_req.wdata = d_wdata;
      end else begin
         win_req.addr  = i_addr;
         win_req.write = 1'b0;
         win_req.size  = SIZE_WORD;
         win_req.wdata = 32'h0;
      end
   end

   // Transfer sequencer: every bus and master output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner_d    <= 1'b0;
         hold_wdata <= 32'h0;
         HADDR      <= 32'h0;
         HWRITE     <= 1'b0;
         HSIZE      <= 3'b000;
         HTRANS     <= HTRANS_IDLE;
         HWDATA     <= 32'h0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         i_rdata    <= 32'h0;
         d_rdata    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner_d    <= grant_d;
                  hold_wdata <= win_req.wdata;
                  HADDR      <= win_req.addr;
                  HWRITE     <= win_req.write;
                  HSIZE      <= win_req.size;
                  HTRANS     <= HTRANS_NONSEQ;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  HWDATA <= hold_wdata;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (HREADY) begin
                  if (!HWRITE) begin
                     if (owner_d) begin
                        d_rdata <= HRDATA;
                     end else begin
                        i_rdata <= HRDATA;
                     end
                  end
                  if (owner_d) begin
                     d_ready <= 1'b1;
                  end else begin
                     i_ready <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Purpose: self-checking bench for ahb_master_arbiter with a scoreboard of expected completions.
// Latency: checks cycle-exact timing of address phase, data phase and ready pulse per scenario.
// Backpressure: drives HREADY low in ADDR and DATA to exercise stalls.
module tb_ahb_master_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic        d_write;
   logic [2:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;

   localparam logic [31:0] RD_KEY = 32'hA5A5_5A5A;

   always #5 clk = ~clk;

   ahb_master_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_ready (i_ready),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_addr  (d_addr),
      .d_write (d_write),
      .d_size  (d_size),
      .d_wdata (d_wdata),
      .d_ready (d_ready),
      .d_rdata (d_rdata),
      .HADDR   (HADDR),
      .HWRITE  (HWRITE),
      .HSIZE   (HSIZE),
      .HTRANS  (HTRANS),
      .HWDATA  (HWDATA),
      .HRDATA  (HRDATA),
      .HREADY  (HREADY)
   );

   int n_chk    = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   typedef struct {
      logic        port;    // 1 = data port, 0 = fetch port
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   // Slave model: remembers the accepted address and returns a value derived from it.
   logic        use_fixed;
   logic [31:0] fixed_rd;
   logic [31:0] ap_addr = 32'h0;

   always @(posedge clk) begin
      if (HTRANS == 2'b10 && HREADY) ap_addr <= HADDR;
   end

   assign HRDATA = use_fixed ? fixed_rd : (ap_addr ^ RD_KEY);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic port, input logic [31:0] rd);
      exp_t e;
      e.port  = port;
      e.rdata = rd;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      if (done_cnt < target) chk("timeout_completions", 32'(done_cnt), 32'(target));
   endtask

   // Completion monitor: every ready pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (i_ready || d_ready) begin
         chk("both_ready", 32'(i_ready & d_ready), 32'd0);
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_ready", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_port", 32'(d_ready), 32'(mon_e.port));
            chk("sb_rdata", d_ready ? d_rdata : i_rdata, mon_e.rdata);
         end
         done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d completions", done_cnt);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      i_req     = 1'b0;
      i_addr    = 32'h0;
      d_req     = 1'b0;
      d_addr    = 32'h0;
      d_write   = 1'b0;
      d_size    = 3'b010;
      d_wdata   = 32'h0;
      HREADY    = 1'b1;
      use_fixed = 1'b0;
      fixed_rd  = 32'h0;
      repeat (2) tick();

      // reset state
      chk("rst_htrans",  32'(HTRANS), 32'h0);
      chk("rst_haddr",   HADDR, 32'h0);
      chk("rst_hwrite",  32'(HWRITE), 32'h0);
      chk("rst_hsize",   32'(HSIZE), 32'h0);
      chk("rst_i_ready", 32'(i_ready), 32'h0);
      chk("rst_d_ready", 32'(d_ready), 32'h0);
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      reset = 1'b0;
      tick();

      // single fetch read, zero wait
      use_fixed = 1'b1;
      fixed_rd  = 32'hE3A0_0001;
      i_req  = 1'b1;
      i_addr = 32'h0000_0100;
      push_exp(1'b0, 32'hE3A0_0001);
      tick();
      chk("rd_c1_htrans", 32'(HTRANS), 32'h2);
      chk("rd_c1_haddr",  HADDR, 32'h0000_0100);
      chk("rd_c1_hsize",  32'(HSIZE), 32'h2);
      chk("rd_c1_hwrite", 32'(HWRITE), 32'h0);
      tick();
      chk("rd_c2_htrans",  32'(HTRANS), 32'h0);
      chk("rd_c2_i_ready", 32'(i_ready), 32'h0);
      tick();
      chk("rd_c3_i_ready", 32'(i_ready), 32'h1);
      chk("rd_c3_d_ready", 32'(d_ready), 32'h0);
      chk("rd_c3_i_rdata", i_rdata, 32'hE3A0_0001);
      tick();
      i_req = 1'b0;
      chk("rd_c4_i_ready", 32'(i_ready), 32'h0);
      chk("rd_c4_i_rdata_hold", i_rdata, 32'hE3A0_0001);
      use_fixed = 1'b0;
      tick();

      // data write with two wait states in DATA
      d_req   = 1'b1;
      d_write = 1'b1;
      d_addr  = 32'h0002_0004;
      d_wdata = 32'hDEAD_BEEF;
      d_size  = 3'b010;
      push_exp(1'b1, 32'h0);
      tick();
      chk("wr_c1_htrans", 32'(HTRANS), 32'h2);
      chk("wr_c1_hwrite", 32'(HWRITE), 32'h1);
      chk("wr_c1_haddr",  HADDR, 32'h0002_0004);
      tick();
      HREADY = 1'b0;
      chk("wr_c2_htrans", 32'(HTRANS), 32'h0);
      chk("wr_c2_hwdata", HWDATA, 32'hDEAD_BEEF);
      tick();
      chk("wr_c3_hwdata",  HWDATA, 32'hDEAD_BEEF);
      chk("wr_c3_d_ready", 32'(d_ready), 32'h0);
      tick();
      HREADY = 1'b1;
      chk("wr_c4_hwdata",  HWDATA, 32'hDEAD_BEEF);
      chk("wr_c4_d_ready", 32'(d_ready), 32'h0);
      tick();
      chk("wr_c5_d_ready", 32'(d_ready), 32'h1);
      chk("wr_c5_d_rdata", d_rdata, 32'h0);
      tick();
      d_req   = 1'b0;
      d_write = 1'b0;
      tick();

      // contention: data first, fetch at the following IDLE
      i_req  = 1'b1;
      i_addr = 32'h0000_0300;
      d_req  = 1'b1;
      d_addr = 32'h0000_0400;
      d_size = 3'b000;
      push_exp(1'b1, 32'h0000_0400 ^ RD_KEY);
      push_exp(1'b0, 32'h0000_0300 ^ RD_KEY);
      tick();
      chk("ct_c1_haddr", HADDR, 32'h0000_0400);
      chk("ct_c1_hsize", 32'(HSIZE), 32'h0);
      tick();
      tick();
      chk("ct_c3_d_ready", 32'(d_ready), 32'h1);
      chk("ct_c3_i_ready", 32'(i_ready), 32'h0);
      tick();
      d_req = 1'b0;
      chk("ct_c4_htrans", 32'(HTRANS), 32'h0);
      tick();
      chk("ct_c5_htrans", 32'(HTRANS), 32'h2);
      chk("ct_c5_haddr",  HADDR, 32'h0000_0300);
      chk("ct_c5_hsize",  32'(HSIZE), 32'h2);
      tick();
      tick();
      chk("ct_c7_i_ready", 32'(i_ready), 32'h1);
      chk("ct_c7_i_rdata", i_rdata, 32'h0000_0300 ^ RD_KEY);
      tick();
      i_req = 1'b0;
      tick();

      // master-side change during a stalled address phase
      d_req  = 1'b1;
      d_addr = 32'h0000_0500;
      d_size = 3'b001;
      push_exp(1'b1, 32'h0000_0500 ^ RD_KEY);
      tick();
      d_addr = 32'h0000_05FC;
      d_size = 3'b010;
      HREADY = 1'b0;
      chk("mc_c1_haddr", HADDR, 32'h0000_0500);
      chk("mc_c1_hsize", 32'(HSIZE), 32'h1);
      tick();
      HREADY = 1'b1;
      chk("mc_c2_htrans", 32'(HTRANS), 32'h2);
      chk("mc_c2_haddr",  HADDR, 32'h0000_0500);
      tick();
      chk("mc_c3_htrans",  32'(HTRANS), 32'h0);
      chk("mc_c3_d_ready", 32'(d_ready), 32'h0);
      tick();
      chk("mc_c4_d_ready", 32'(d_ready), 32'h1);
      chk("mc_c4_d_rdata", d_rdata, 32'h0000_0500 ^ RD_KEY);
      tick();
      d_req = 1'b0;
      tick();

      // reset during DATA: transfer abandoned, no ready pulse
      d_req  = 1'b1;
      d_addr = 32'h0000_0600;
      tick();
      tick();
      HREADY = 1'b0;
      reset  = 1'b1;
      tick();
      chk("mr_htrans",  32'(HTRANS), 32'h0);
      chk("mr_haddr",   HADDR, 32'h0);
      chk("mr_hwdata",  HWDATA, 32'h0);
      chk("mr_i_ready", 32'(i_ready), 32'h0);
      chk("mr_d_ready", 32'(d_ready), 32'h0);
      chk("mr_d_rdata", d_rdata, 32'h0);
      chk("mr_i_rdata", i_rdata, 32'h0);
      reset  = 1'b0;
      d_req  = 1'b0;
      HREADY = 1'b1;
      repeat (6) tick();
      d_req  = 1'b1;
      d_addr = 32'h0000_0700;
      push_exp(1'b1, 32'h0000_0700 ^ RD_KEY);
      tick();
      chk("mr_next_c1_htrans", 32'(HTRANS), 32'h2);
      chk("mr_next_c1_haddr",  HADDR, 32'h0000_0700);
      tick();
      tick();
      chk("mr_next_c3_d_ready", 32'(d_ready), 32'h1);
      tick();
      d_req = 1'b0;
      tick();

      // starvation: both ports request continuously for ten completions
      i_addr = 32'h0000_1000;
      d_addr = 32'h0000_2000;
      d_size = 3'b010;
      for (int k = 0; k < 10; k++) begin
         logic p;
`ifdef AHB_ARB_FAIR_EN
         p = ((k % 5) != 4);
`else
         p = 1'b1;
`endif
         push_exp(p, p ? (32'h0000_2000 ^ RD_KEY) : (32'h0000_1000 ^ RD_KEY));
      end
      i_req = 1'b1;
      d_req = 1'b1;
      wait_done(done_cnt + 10, 100);
      i_req = 1'b0;
      d_req = 1'b0;
      repeat (8) tick();

      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master AHB-Lite arbiter and transfer sequencer for the pipelined core. It shares the single AHB-Lite bus, whose slaves are selected by the address decoder, between the instruction-fetch port (master 0) and the data-memory port (master 1). It grants one master at a time and drives address and data phases. It returns read data and a one-cycle completion pulse to the owning master.

## Interface
- STARVE_LIMIT, default 4: consecutive contested data-port wins before the fetch port is forced a grant (used only with the fairness feature).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  32  fetch address.
- i_ready  out  1  one-cycle pulse: fetch transfer complete, i_rdata valid.
- i_rdata  out  32  fetch read data; holds until the next fetch completion.
- d_req  in  1  data request; held until d_ready.
- d_addr  in  32  data address.
- d_write  in  1  1 = write.
- d_size  in  3  HSIZE encoding.
- d_wdata  in  32  write data.
- d_ready  out  1  one-cycle pulse: data transfer complete.
- d_rdata  out  32  data read result; holds until the next data completion.
- HADDR  out  32  bus address.
- HWRITE  out  1  bus write.
- HSIZE  out  3  bus size; fetch transfers always use 3'b010.
- HTRANS  out  2  2'b10 (NONSEQ) in the address phase, otherwise 2'b00 (IDLE).
- HWDATA  out  32  write data in the data phase.
- HRDATA  in  32  slave read data.
- HREADY  in  1  slave ready.

## Operation
- States: IDLE, ADDR, DATA, RESP. All bus and master outputs come from registers.
- **IDLE**: sample i_req and d_req.
  - If either is asserted, latch the winner's addr, write, size and wdata into holding registers, record the owner, and go to ADDR.
  - The fetch port always drives write = 0 and size = 010.
- **ADDR**: HTRANS = NONSEQ; HADDR, HWRITE and HSIZE come from the holding registers. Advance to DATA on HREADY = 1; otherwise hold all outputs.
- **DATA**: HTRANS = IDLE; HWDATA comes from the holding register. On HREADY = 1, capture HRDATA into the owner's rdata register (reads only) and go to RESP; otherwise wait.
- **RESP**: pulse the owner's ready for exactly one cycle, then return to IDLE.
  - The master must deassert or change req in the cycle after its ready pulse.
  - Requests presented during RESP are ignored.
- Arbitration priority: the data port wins when both request.
- Requests that arrive or change while a transfer is in flight (ADDR, DATA, RESP) have no effect until IDLE. The holding registers isolate the bus from master-side changes.
- **Reset** (including mid-transfer):
  - state = IDLE; HTRANS = 00; HADDR, HWDATA, HSIZE = 0; HWRITE = 0.
  - i_ready, d_ready = 0; i_rdata, d_rdata = 0; fairness counter = 0.
  - Any in-flight transfer is abandoned with no ready pulse.

## Timing
- With zero wait states, d_req or i_req asserted in cycle 0 (IDLE) gives:
  - cycle 1: ADDR
  - cycle 2: DATA
  - cycle 3: ready = 1 with rdata valid
  - cycle 4: IDLE, which samples the next request.
- Minimum latency is 3 cycles; throughput is one transfer per 4 cycles.
- Each HREADY-low cycle in ADDR or DATA adds exactly one cycle of latency.
- Ready is never asserted for both ports in the same cycle, and never for a port that was not the owner.

## Configuration
- AHB_ARB_FAIR_EN defined:
  - A counter with width of at least $clog2(STARVE_LIMIT + 1) increments on each IDLE grant to data while i_req = 1.
  - When the count equals STARVE_LIMIT and both request, fetch is granted and the counter clears.
  - The counter also clears on any fetch grant and on any data grant made while i_req = 0.
- AHB_ARB_FAIR_EN undefined: strict data-over-fetch priority; no counter logic.

## Test plan
- **Single read, zero wait**: i_req = 1, i_addr = 0x00000100, HRDATA = 0xE3A00001.
  - Cycle 1: HTRANS = 10, HADDR = 0x100, HSIZE = 010.
  - Cycle 3: i_ready = 1, i_rdata = 0xE3A00001.
- **Write with wait states**: d_req = 1, d_write = 1, d_addr = 0x00020004, d_wdata = 0xDEADBEEF, HREADY low for 2 cycles in DATA.
  - HWDATA = 0xDEADBEEF held throughout DATA.
  - d_ready pulses at cycle 5.
- **Contention**: both requests in the same cycle.
  - The data transfer is issued first; d_ready pulses at cycle 3.
  - The fetch is granted at the cycle-4 IDLE; i_ready pulses at cycle 7.
- **Starvation**: with AHB_ARB_FAIR_EN and STARVE_LIMIT = 4, hold both requests continuously.
  - Grant order: D, D, D, D, I, D, D, D, D, I.
  - Without the macro: data only.
- **Reset mid-transfer**: assert reset during DATA.
  - Next cycle: HTRANS = 00, both ready outputs 0, state IDLE, no ready pulse.
  - A following request completes normally.
- **Master-side change**: change d_addr during ADDR. HADDR keeps the latched value.
